// File: rtl/inv_shift_rows_serial.sv
`timescale 1ns/1ps
// inv_shift_rows_serial
//   Byte-serial AES (Inv)ShiftRows. A 16-byte state block is loaded in
//   FIPS-197 byte order (byte k = row k%4, column k/4) into a local buffer,
//   then streamed back out permuted. FORWARD=0 performs InvShiftRows,
//   FORWARD=1 performs ShiftRows.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data/in_last valid
//   in_ready   block accepts an input byte this cycle (LOAD phase)
//   in_data    input state byte
//   in_last    marks byte 15 of a block
//   out_valid  out_data/out_last valid (EMIT phase)
//   out_ready  downstream accepts the output byte
//   out_data   transformed state byte, 8'h00 when idle
//   out_last   high with output byte 15
//   frame_err  one-cycle pulse when in_last is misaligned with byte 15
module inv_shift_rows_serial #(
    parameter int FORWARD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       frame_err
);

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wr_cnt_q, wr_cnt_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic        init_q, init_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        frame_err_q, frame_err_d;

    logic [7:0]  mem_q [16];
    logic        mem_we;
    logic        in_hs;
    logic        out_hs;

    // Source buffer index for output position k = r + 4c.
    // Inverse: column (c - r) mod 4; forward: column (c + r) mod 4.
    function automatic logic [3:0] src_idx(input logic [3:0] k);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] col;
        r = k[1:0];
        c = k[3:2];
        if (FORWARD != 0) begin
            col = c + r;
        end else begin
            col = c - r;
        end
        return {col, r};
    endfunction

    // init_q holds in_ready low through reset and releases it on the first
    // clock edge after deassertion.
    assign in_ready  = init_q && (state_q == LOAD);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign frame_err = frame_err_q;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        init_d      = 1'b1;
        mem_we      = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            LOAD: begin
                if (in_hs) begin
                    if (wr_cnt_q == 4'd15) begin
                        // Block completes even when in_last is missing.
                        mem_we      = 1'b1;
                        wr_cnt_d    = '0;
                        rd_cnt_d    = '0;
                        state_d     = EMIT;
                        frame_err_d = !in_last;
                    end else if (in_last) begin
                        // Early in_last: drop the partial block, byte not stored.
                        wr_cnt_d    = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 4'd1;
                    end
                end
            end
            EMIT: begin
                if (out_hs) begin
                    rd_cnt_d = rd_cnt_q + 4'd1;
                    if (rd_cnt_q == 4'd15) begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        // Output registers are loaded with the byte for the next rd_cnt. On
        // entry to EMIT that is source index 0, never the entry 15 being
        // written on the same edge, so no write-to-read bypass is needed.
        out_valid_d = (state_d == EMIT);
        out_last_d  = (state_d == EMIT) && (rd_cnt_d == 4'd15);
        out_data_d  = (state_d == EMIT) ? mem_q[src_idx(rd_cnt_d)] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            init_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            init_q      <= init_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Block buffer: written only in LOAD, no reset needed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_cnt_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
`timescale 1ns/1ps
// Bench for inv_shift_rows_serial: an inverse (FORWARD=0) and a forward
// (FORWARD=1) instance share the input stream and out_ready. Expected bytes
// are queued per instance when a block is issued; a monitor pops and
// compares on every output handshake.
module tb_inv_shift_rows_serial;

    typedef logic [7:0] blk_t [16];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;
    logic       stall_en = 1'b0;

    logic       ir [2];
    logic       ov [2];
    logic [7:0] od [2];
    logic       ol [2];
    logic       fe [2];

    logic [8:0] q [2][$];

    int total = 0;
    int bad   = 0;

    // Hand-written permutation tables: output byte k takes input byte PERM[k].
    int INV_PERM [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
    int FWD_PERM [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

    blk_t seq_in   = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                       8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    blk_t seq_inv  = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                       8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    blk_t seq_fwd  = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                       8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    // FIPS-197 App. B, round 1 state after SubBytes and after ShiftRows.
    blk_t fips_sb  = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                       8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    blk_t fips_sr  = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                       8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};

    inv_shift_rows_serial #(.FORWARD(0)) u_inv (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (ir[0]),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (ov[0]),
        .out_ready (out_ready),
        .out_data  (od[0]),
        .out_last  (ol[0]),
        .frame_err (fe[0])
    );

    inv_shift_rows_serial #(.FORWARD(1)) u_fwd (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (ir[1]),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (ov[1]),
        .out_ready (out_ready),
        .out_data  (od[1]),
        .out_last  (ol[1]),
        .frame_err (fe[1])
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic blk_t permute(input blk_t b, input bit fwd);
        blk_t r;
        for (int k = 0; k < 16; k++) begin
            r[k] = fwd ? b[FWD_PERM[k]] : b[INV_PERM[k]];
        end
        return r;
    endfunction

    task automatic push_blk(input blk_t e_inv, input blk_t e_fwd);
        for (int k = 0; k < 16; k++) begin
            q[0].push_back({(k == 15), e_inv[k]});
            q[1].push_back({(k == 15), e_fwd[k]});
        end
    endtask

    // Send n bytes of b; in_last is raised on byte index last_at (-1: never).
    // Returns 1 ns after the clock edge that took the final byte.
    task automatic send_block(input blk_t b, input int n, input int last_at, input bit rand_valid);
        int  k = 0;
        int  budget = 0;
        logic hs;
        while (k < n) begin
            in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = b[k];
            in_last  = (k == last_at);
            @(negedge clk);
            hs = in_valid && ir[0];
            @(posedge clk);
            #1;
            if (hs) k++;
            budget++;
            if (budget > 3000) begin
                chk("send_timeout", 32'(k), 32'(n));
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 32'(q[0].size() + q[1].size()), 32'd0);
        for (int i = 0; i < 2; i++) chk("ready_after_emit", 32'(ir[i]), 32'd1);
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Monitor: compare every output handshake against the queue, check that a
    // stalled byte holds its value, and that the idle output reads zero.
    logic       held_v [2] = '{1'b0, 1'b0};
    logic [7:0] held_d [2];
    logic       held_l [2];
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                held_v[i] = 1'b0;
            end else if (ov[i]) begin
                if (held_v[i]) begin
                    chk(i == 0 ? "inv_stall_data" : "fwd_stall_data", 32'(od[i]), 32'(held_d[i]));
                    chk(i == 0 ? "inv_stall_last" : "fwd_stall_last", 32'(ol[i]), 32'(held_l[i]));
                end
                if (out_ready) begin
                    held_v[i] = 1'b0;
                    if (q[i].size() == 0) begin
                        chk(i == 0 ? "inv_unexpected_out" : "fwd_unexpected_out", 32'(od[i]), 32'h1ff);
                    end else begin
                        logic [8:0] e;
                        e = q[i].pop_front();
                        chk(i == 0 ? "inv_out_data" : "fwd_out_data", 32'(od[i]), 32'(e[7:0]));
                        chk(i == 0 ? "inv_out_last" : "fwd_out_last", 32'(ol[i]), 32'(e[8]));
                    end
                end else begin
                    held_v[i] = 1'b1;
                    held_d[i] = od[i];
                    held_l[i] = ol[i];
                end
            end else begin
                held_v[i] = 1'b0;
                chk(i == 0 ? "inv_idle_data" : "fwd_idle_data", 32'(od[i]), 32'd0);
            end
        end
    end

    initial begin
        blk_t b;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", 32'(ir[i]), 32'd0);
            chk("rst_out_valid", 32'(ov[i]), 32'd0);
            chk("rst_out_last", 32'(ol[i]), 32'd0);
            chk("rst_frame_err", 32'(fe[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk("ready_after_rst", 32'(ir[i]), 32'd1);

        // Bytes 00..0F, one-cycle latency to out_valid
        push_blk(seq_inv, seq_fwd);
        send_block(seq_in, 16, 15, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("latency_out_valid", 32'(ov[i]), 32'd1);
            chk("emit_in_ready", 32'(ir[i]), 32'd0);
            chk("good_frame_err", 32'(fe[i]), 32'd0);
        end
        wait_drain();

        // FIPS-197 round state, then its ShiftRows image fed back (round trip)
        push_blk(permute(fips_sb, 1'b0), fips_sr);
        send_block(fips_sb, 16, 15, 1'b0);
        wait_drain();
        push_blk(fips_sb, permute(fips_sr, 1'b1));
        send_block(fips_sr, 16, 15, 1'b0);
        wait_drain();

        // Early in_last on byte 5: pulse, block dropped
        send_block(seq_in, 6, 5, 1'b0);
        for (int i = 0; i < 2; i++) chk("early_last_err", 32'(fe[i]), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("err_one_cycle", 32'(fe[i]), 32'd0);
            chk("early_no_valid", 32'(ov[i]), 32'd0);
            chk("early_ready", 32'(ir[i]), 32'd1);
        end
        for (int k = 0; k < 16; k++) b[k] = 8'hF0 + 8'(k);
        push_blk(permute(b, 1'b0), permute(b, 1'b1));
        send_block(b, 16, 15, 1'b0);
        wait_drain();

        // Missing in_last on byte 15: pulse, block still emitted
        for (int k = 0; k < 16; k++) b[k] = 8'h3C ^ 8'(k * 17);
        push_blk(permute(b, 1'b0), permute(b, 1'b1));
        send_block(b, 16, -1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("missing_last_err", 32'(fe[i]), 32'd1);
            chk("missing_last_valid", 32'(ov[i]), 32'd1);
        end
        wait_drain();

        // Reset after output byte 7
        for (int k = 0; k < 16; k++) b[k] = 8'hA0 + 8'(k);
        push_blk(permute(b, 1'b0), permute(b, 1'b1));
        send_block(b, 16, 15, 1'b0);
        begin
            int n = 0;
            while (q[0].size() > 8 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("mid_emit_left", 32'(q[0].size()), 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_rst_valid", 32'(ov[i]), 32'd0);
            chk("async_rst_data", 32'(od[i]), 32'd0);
            chk("async_rst_ready", 32'(ir[i]), 32'd0);
        end
        q[0].delete();
        q[1].delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk("ready_after_mid_rst", 32'(ir[i]), 32'd1);
        for (int k = 0; k < 16; k++) b[k] = 8'h5A - 8'(k);
        push_blk(permute(b, 1'b0), permute(b, 1'b1));
        send_block(b, 16, 15, 1'b0);
        wait_drain();

        // Random data with random input and output stalls
        stall_en = 1'b1;
        for (int blk = 0; blk < 100; blk++) begin
            for (int k = 0; k < 16; k++) b[k] = 8'($urandom_range(0, 255));
            push_blk(permute(b, 1'b0), permute(b, 1'b1));
            send_block(b, 16, 15, 1'b1);
            wait_drain();
        end
        stall_en = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_shift_rows_serial.md
INV_SHIFT_ROWS_SERIAL -- requirements
Module: inv_shift_rows_serial

Interface
REQ-001 SHALL have parameter FORWARD, default 0; 0 = InvShiftRows, 1 = ShiftRows (forward, for self-check).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  in_data/in_last valid.
REQ-005 SHALL have port in_ready  output  1  block accepts an input byte this cycle.
REQ-006 SHALL have port in_data  input  8  state byte, FIPS-197 order: byte k = row (k mod 4), column (k div 4); byte 0 first.
REQ-007 SHALL have port in_last  input  1  marks byte 15 of a block.
REQ-008 SHALL have port out_valid  output  1  out_data/out_last valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the output byte.
REQ-010 SHALL have port out_data  output  8  transformed state byte, same byte order as input.
REQ-011 SHALL have port out_last  output  1  high with output byte 15.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on in_last misalignment.

Function
REQ-013 SHALL implement two states: LOAD (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-014 In LOAD, an input handshake (in_valid & in_ready) SHALL write in_data into 16x8 buffer entry wr_cnt and increment 4-bit wr_cnt.
REQ-015 Handshake with wr_cnt=15 SHALL wrap wr_cnt to 0 and move to EMIT on the next cycle; out_valid SHALL rise the cycle after the 16th input handshake (1-cycle latency).
REQ-016 In EMIT, out_data SHALL equal buf[r + 4*((c - r) mod 4)] for FORWARD=0, or buf[r + 4*((c + r) mod 4)] for FORWARD=1, where rd_cnt = r + 4c.
REQ-017 out_data, out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 Each output handshake SHALL increment 4-bit rd_cnt; out_last SHALL be 1 only when rd_cnt=15.
REQ-019 Handshake with rd_cnt=15 SHALL wrap rd_cnt to 0 and return to LOAD on the next cycle; in_ready SHALL be 1 that next cycle.
REQ-020 Minimum block period SHALL be 32 cycles (16 load + 16 emit) with in_valid and out_ready held high.
REQ-021 in_valid SHALL be ignored in EMIT; out_ready SHALL be ignored in LOAD.
REQ-022 in_last=1 on a handshake with wr_cnt!=15 SHALL pulse frame_err, discard the partial block (wr_cnt to 0, stay in LOAD), and not write the byte.
REQ-023 in_last=0 on the handshake with wr_cnt=15 SHALL pulse frame_err, still complete the block and enter EMIT.
REQ-024 Buffer contents SHALL not change during EMIT.
REQ-025 out_data SHALL be 8'h00 when out_valid=0.

Reset
REQ-026 rst_n=0 SHALL, asynchronously, force state LOAD, wr_cnt=0, rd_cnt=0, frame_err=0, out_valid=0, out_last=0, out_data=8'h00.
REQ-027 in_ready SHALL be 0 while rst_n=0 and 1 from the first clk edge after deassertion.
REQ-028 Reset mid-load or mid-emit SHALL abandon the block; no stale output byte SHALL appear after reset.
REQ-029 Buffer contents need no reset value.

Verification
REQ-030 FORWARD=0, bytes 00..0F, in_last on 0F, out_ready=1 -> output 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03, out_last on final 03, first out_valid 1 cycle after input 0F.
REQ-031 FORWARD=1, same input -> 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B.
REQ-032 Round trip FORWARD=1 into FORWARD=0 instance, FIPS-197 App. B round state -> output equals original input bytes.
REQ-033 Random out_ready/in_valid stalls, 100 random blocks -> byte sequence identical to the no-stall run, out_data stable during stalls.
REQ-034 in_last on byte 5 -> frame_err one-cycle pulse, no out_valid; next full 16-byte block transforms correctly.
REQ-035 rst_n low for 1 cycle after output byte 7 of a block -> out_valid=0 immediately, in_ready=1 after release, next block output correct.
